// File: rtl/wb_queue.sv
// wb_queue: dual-producer (fp, int) writeback FIFO feeding one register-file write port with rsv release
`ifndef WB_QUEUE_DEPTH
`define WB_QUEUE_DEPTH 16
`endif
package gDefine;
  typedef logic [10:0] GRegIdx_t;
  typedef logic [15:0] Mask_t;
  typedef logic [511:0] Vector_t;
  typedef logic [4:0] RsvID_t;
  typedef struct packed {
    GRegIdx_t r;
    Mask_t m;
    Vector_t d;
    RsvID_t v;
  } WbEnt_t;
endpackage
module wb_queue
  import gDefine::*;
#(
  parameter int DEPTH = `WB_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fp_valid,
  output logic                         fp_ready,
  input  GRegIdx_t                     fp_reg,
  input  Mask_t                        fp_mask,
  input  Vector_t                      fp_data,
  input  RsvID_t                       fp_rsv,
  input  logic                         int_valid,
  output logic                         int_ready,
  input  GRegIdx_t                     int_reg,
  input  Mask_t                        int_mask,
  input  Vector_t                      int_data,
  input  RsvID_t                       int_rsv,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output GRegIdx_t                     wb_reg,
  output Mask_t                        wb_mask,
  output Vector_t                      wb_data,
  output RsvID_t                       wb_rsv,
  output logic                         rsv_free_valid,
  output RsvID_t                       rsv_free_id,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  WbEnt_t ent_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, int_wa;
  logic [CW-1:0] count_q, count_d;
  logic fp_push, int_push, pop;
  always_comb begin
    fp_ready = count_q < CW'(DEPTH);
    int_ready = (count_q <= CW'(DEPTH-2)) | ((count_q == CW'(DEPTH-1)) & !fp_valid);
    fp_push = fp_valid & fp_ready;
    int_push = int_valid & int_ready;
    wb_valid = count_q != '0;
    pop = wb_valid & wb_ready;
    int_wa = wptr_q + AW'(fp_push);
    wptr_d = int_wa + AW'(int_push);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + CW'(fp_push) + CW'(int_push) - CW'(pop);
    {wb_reg, wb_mask, wb_data, wb_rsv} = ent_q[rptr_q];
    rsv_free_valid = pop;
    rsv_free_id = wb_rsv;
    count = count_q;
  end
  always_ff @(posedge clk) begin
    if (fp_push) ent_q[wptr_q] <= '{fp_reg, fp_mask, fp_data, fp_rsv};
    if (int_push) ent_q[int_wa] <= '{int_reg, int_mask, int_data, int_rsv};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized check of wb_queue against a queue-based reference model
module tb_wb_queue;
  localparam int D = 16;
  typedef struct packed {
    logic [10:0] r;
    logic [15:0] m;
    logic [511:0] d;
    logic [4:0] v;
  } ent_t;
  logic clk = 0, rst_n = 0;
  logic fp_valid = 0, int_valid = 0, wb_ready = 0;
  logic [10:0] fp_reg = 0, int_reg = 0;
  logic [15:0] fp_mask = 0, int_mask = 0;
  logic [511:0] fp_data = 0, int_data = 0;
  logic [4:0] fp_rsv = 0, int_rsv = 0;
  logic fp_ready, int_ready, wb_valid, rsv_free_valid;
  logic [10:0] wb_reg;
  logic [15:0] wb_mask;
  logic [511:0] wb_data;
  logic [4:0] wb_rsv, rsv_free_id;
  logic [4:0] count;
  ent_t q[$];
  int checks = 0, errors = 0;
  wb_queue #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_reg(fp_reg), .fp_mask(fp_mask), .fp_data(fp_data), .fp_rsv(fp_rsv),
    .int_valid(int_valid), .int_ready(int_ready), .int_reg(int_reg), .int_mask(int_mask), .int_data(int_data), .int_rsv(int_rsv),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_mask(wb_mask), .wb_data(wb_data), .wb_rsv(wb_rsv),
    .rsv_free_valid(rsv_free_valid), .rsv_free_id(rsv_free_id), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask
  function automatic logic [511:0] rnd_data();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom();
    return x;
  endfunction
  task automatic payload();
    fp_reg = 11'($urandom()); fp_mask = 16'($urandom()); fp_data = rnd_data(); fp_rsv = 5'($urandom());
    int_reg = 11'($urandom()); int_mask = 16'($urandom()); int_data = rnd_data(); int_rsv = 5'($urandom());
    if ($urandom_range(0, 7) == 0) fp_mask = 16'h0;
    if ($urandom_range(0, 7) == 0) int_mask = 16'h0;
  endtask
  task automatic tick();
    int n;
    logic efr, eir, epop;
    #1;
    n = q.size();
    efr = n < D;
    eir = (n <= D - 2) || (n == D - 1 && !fp_valid);
    epop = n != 0 && wb_ready;
    chk("count", 512'(count), 512'(n));
    chk("wb_valid", 512'(wb_valid), 512'(n != 0));
    chk("fp_ready", 512'(fp_ready), 512'(efr));
    chk("int_ready", 512'(int_ready), 512'(eir));
    chk("rsv_free_valid", 512'(rsv_free_valid), 512'(epop));
    if (n != 0) begin
      chk("wb_reg", 512'(wb_reg), 512'(q[0].r));
      chk("wb_mask", 512'(wb_mask), 512'(q[0].m));
      chk("wb_data", wb_data, q[0].d);
      chk("wb_rsv", 512'(wb_rsv), 512'(q[0].v));
      chk("rsv_free_id", 512'(rsv_free_id), 512'(q[0].v));
    end
    if (epop) void'(q.pop_front());
    if (fp_valid && efr) q.push_back('{fp_reg, fp_mask, fp_data, fp_rsv});
    if (int_valid && eir) q.push_back('{int_reg, int_mask, int_data, int_rsv});
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic fv, input logic iv, input logic wr);
    payload();
    fp_valid = fv; int_valid = iv; wb_ready = wr;
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < 2 * D && q.size() < n; i++) begin
      drive(1, 0, 0);
      tick();
    end
    chk("fill_level", 512'(q.size()), 512'(n));
  endtask
  task automatic drain();
    for (int i = 0; i < 2 * D && q.size() != 0; i++) begin
      drive(0, 0, 1);
      tick();
    end
  endtask
  initial begin
    #2;
    wb_ready = 1;
    #1;
    chk("rst_count", 512'(count), 512'(0));
    chk("rst_wb_valid", 512'(wb_valid), 512'(0));
    chk("rst_rsv_free", 512'(rsv_free_valid), 512'(0));
    chk("rst_fp_ready", 512'(fp_ready), 512'(1));
    chk("rst_int_ready", 512'(int_ready), 512'(1));
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 1);
    tick();
    drive(1, 0, 1);
    fp_reg = 11'd5; fp_rsv = 5'd3; fp_mask = 16'hFFFF;
    tick();
    wb_ready = 1; fp_valid = 0;
    #1;
    chk("s1_reg", 512'(wb_reg), 512'(5));
    chk("s1_free_id", 512'(rsv_free_id), 512'(3));
    chk("s1_free_valid", 512'(rsv_free_valid), 512'(1));
    tick();
    chk("s1_empty", 512'(count), 512'(0));
    drive(1, 1, 0);
    fp_rsv = 5'd1; int_rsv = 5'd2;
    tick();
    drive(0, 0, 1);
    #1;
    chk("s2_count", 512'(count), 512'(2));
    chk("s2_first", 512'(rsv_free_id), 512'(1));
    tick();
    chk("s2_second", 512'(rsv_free_id), 512'(2));
    tick();
    fill(D - 1);
    drive(1, 1, 0);
    #1;
    chk("s3_fp_ready", 512'(fp_ready), 512'(1));
    chk("s3_int_ready", 512'(int_ready), 512'(0));
    tick();
    drive(1, 1, 0);
    #1;
    chk("s3_full", 512'(count), 512'(D));
    chk("s3_fp_blocked", 512'(fp_ready), 512'(0));
    chk("s3_int_blocked", 512'(int_ready), 512'(0));
    tick();
    drive(1, 0, 1);
    tick();
    drive(0, 0, 0);
    #1;
    chk("s5_count", 512'(count), 512'(D - 1));
    chk("s5_fp_ready", 512'(fp_ready), 512'(1));
    tick();
    drain();
    fill(8);
    for (int i = 0; i < 40; i++) begin
      if (i[0]) drive(1, 0, 1); else drive(0, 1, 1);
      tick();
      chk("s4_stable", 512'(q.size()), 512'(8));
    end
    drain();
    fill(7);
    drive(0, 0, 1);
    #1;
    rst_n = 0;
    #1;
    chk("s6_wb_valid", 512'(wb_valid), 512'(0));
    chk("s6_count", 512'(count), 512'(0));
    chk("s6_free", 512'(rsv_free_valid), 512'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      tick();
    end
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < (i < 1000 ? 40 : 85));
      tick();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
